// File: rtl/position_registers.sv
// Tic-tac-toe board store: nine 2-bit cells, turn order, move count and error pulse.
// Optional UNDO_EN adds an undo input that retracts the last committed move.
module position_registers #(
   parameter int ERR_HOLD = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [8:0] PL_en,
   input  logic [8:0] PC_en,
   input  logic       illegal_move,
`ifdef UNDO_EN
   input  logic       undo,
`endif
   output logic [1:0] pos1,
   output logic [1:0] pos2,
   output logic [1:0] pos3,
   output logic [1:0] pos4,
   output logic [1:0] pos5,
   output logic [1:0] pos6,
   output logic [1:0] pos7,
   output logic [1:0] pos8,
   output logic [1:0] pos9,
   output logic       turn,
   output logic [3:0] move_cnt,
   output logic       board_full,
   output logic       move_ack,
   output logic       move_err
);

   localparam int EW = $clog2(ERR_HOLD + 1);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      FULL
   } state_t;

   state_t           state_q, state_d;
   logic [8:0][1:0]  cell_q, cell_d;
   logic             turn_q, turn_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             full_q, full_d;
   logic             ack_q, ack_d;
   logic [EW-1:0]    err_q, err_d;

   logic             req;
   logic [17:0]      both;
   logic             one_hot;
   logic             side_ok;
   logic             legal;
   logic [8:0]       sel;
   logic [3:0]       sel_idx;

`ifdef UNDO_EN
   logic [3:0]       last_q, last_d;
   logic             last_vld_q, last_vld_d;
   logic             undo_ok;
`endif

   always_comb begin
      req     = (|PL_en) | (|PC_en);
      both    = {PC_en, PL_en};
      one_hot = (both != 18'd0) && ((both & (both - 18'd1)) == 18'd0);
      side_ok = turn_q ? (|PC_en) : (|PL_en);
      legal   = one_hot && side_ok && !illegal_move;
      sel     = turn_q ? PC_en : PL_en;
      sel_idx = 4'd0;
      for (int k = 0; k < 9; k++) begin
         if (sel[k]) sel_idx = 4'(k);
      end
   end

   always_comb begin
      state_d = state_q;
      cell_d  = cell_q;
      turn_d  = turn_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      err_d   = (err_q != '0) ? err_q - EW'(1) : '0;
`ifdef UNDO_EN
      last_d     = last_q;
      last_vld_d = last_vld_q;
      undo_ok    = undo && !req && last_vld_q && (cnt_q != 4'd0);
`endif
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (legal) begin
                  cell_d[sel_idx] = turn_q ? 2'b10 : 2'b01;
                  turn_d  = ~turn_q;
                  cnt_d   = cnt_q + 4'd1;
                  ack_d   = 1'b1;
                  state_d = (cnt_q == 4'd8) ? FULL : HOLD;
`ifdef UNDO_EN
                  last_d     = sel_idx;
                  last_vld_d = 1'b1;
`endif
               end else begin
                  err_d   = EW'(ERR_HOLD);
                  state_d = HOLD;
               end
            end
`ifdef UNDO_EN
            else if (undo_ok) begin
               cell_d[last_q] = 2'b00;
               cnt_d      = cnt_q - 4'd1;
               turn_d     = ~turn_q;
               last_vld_d = 1'b0;
            end
`endif
         end
         // Wait for a full release so a held enable commits only once
         HOLD: begin
            if (!req) state_d = IDLE;
         end
         FULL: begin
            if (req) err_d = EW'(ERR_HOLD);
`ifdef UNDO_EN
            else if (undo_ok) begin
               cell_d[last_q] = 2'b00;
               cnt_d      = cnt_q - 4'd1;
               turn_d     = ~turn_q;
               last_vld_d = 1'b0;
               state_d    = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      full_d = (cnt_d == 4'd9);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cell_q  <= '0;
         turn_q  <= 1'b0;
         cnt_q   <= 4'd0;
         full_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cell_q  <= cell_d;
         turn_q  <= turn_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

`ifdef UNDO_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_q     <= 4'd0;
         last_vld_q <= 1'b0;
      end else begin
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
      end
   end
`endif

   assign pos1       = cell_q[0];
   assign pos2       = cell_q[1];
   assign pos3       = cell_q[2];
   assign pos4       = cell_q[3];
   assign pos5       = cell_q[4];
   assign pos6       = cell_q[5];
   assign pos7       = cell_q[6];
   assign pos8       = cell_q[7];
   assign pos9       = cell_q[8];
   assign turn       = turn_q;
   assign move_cnt   = cnt_q;
   assign board_full = full_q;
   assign move_ack   = ack_q;
   assign move_err   = (err_q != '0);

endmodule

// File: tb/tb_position_registers.sv
// Randomised bench for position_registers against a game-level board model.
// Directed literal checks pin the model on the key scenarios.
module tb_position_registers;

   localparam int ERR_HOLD = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [8:0] PL_en;
   logic [8:0] PC_en;
   logic       illegal_move;
`ifdef UNDO_EN
   logic       undo;
`endif
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   logic       turn;
   logic [3:0] move_cnt;
   logic       board_full;
   logic       move_ack;
   logic       move_err;
   logic [1:0] posv [9];

   int total = 0;
   int bad   = 0;
   bit chk_on = 0;

   int board [9];
   bit m_turn;
   int m_cnt;
   bit m_wait;
   int m_err;
   bit m_ack;
   int m_last;
   bit m_last_ok;

   position_registers #(.ERR_HOLD(ERR_HOLD)) dut (
      .clock       (clock),
      .reset       (reset),
      .PL_en       (PL_en),
      .PC_en       (PC_en),
      .illegal_move(illegal_move),
`ifdef UNDO_EN
      .undo        (undo),
`endif
      .pos1        (pos1),
      .pos2        (pos2),
      .pos3        (pos3),
      .pos4        (pos4),
      .pos5        (pos5),
      .pos6        (pos6),
      .pos7        (pos7),
      .pos8        (pos8),
      .pos9        (pos9),
      .turn        (turn),
      .move_cnt    (move_cnt),
      .board_full  (board_full),
      .move_ack    (move_ack),
      .move_err    (move_err)
   );

   always #5 clock = ~clock;

   assign posv[0] = pos1;
   assign posv[1] = pos2;
   assign posv[2] = pos3;
   assign posv[3] = pos4;
   assign posv[4] = pos5;
   assign posv[5] = pos6;
   assign posv[6] = pos7;
   assign posv[7] = pos8;
   assign posv[8] = pos9;

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 9; k++) board[k] = 0;
      m_turn = 0;
      m_cnt = 0;
      m_wait = 0;
      m_err = 0;
      m_ack = 0;
      m_last = 0;
      m_last_ok = 0;
   endtask

   // Game rules applied to the inputs sampled on the edge just taken
   task automatic model_step();
      logic [17:0] v;
      bit req;
      int idx;
      v = {PC_en, PL_en};
      req = (v != 0);
      idx = 0;
      m_ack = 0;
      if (m_err > 0) m_err--;
      if (m_wait) begin
         if (!req) m_wait = 0;
      end else if (req) begin
         if (m_cnt == 9) begin
            m_err = ERR_HOLD;
         end else if ($countones(v) == 1 && ((PC_en != 0) == m_turn)
                      && !illegal_move) begin
            for (int k = 0; k < 18; k++) if (v[k]) idx = k % 9;
            board[idx] = m_turn ? 2 : 1;
            m_turn = !m_turn;
            m_cnt++;
            m_ack = 1;
            m_last = idx;
            m_last_ok = 1;
            m_wait = (m_cnt != 9);
         end else begin
            m_err = ERR_HOLD;
            m_wait = 1;
         end
      end
`ifdef UNDO_EN
      else if (undo && m_cnt > 0 && m_last_ok) begin
         board[m_last] = 0;
         m_cnt--;
         m_turn = !m_turn;
         m_last_ok = 0;
      end
`endif
   endtask

   always @(negedge clock) begin
      if (chk_on) begin
         for (int k = 0; k < 9; k++)
            cmp($sformatf("pos%0d", k + 1), 32'(posv[k]), 32'(board[k]));
         cmp("turn", 32'(turn), 32'(m_turn));
         cmp("move_cnt", 32'(move_cnt), 32'(m_cnt));
         cmp("board_full", 32'(board_full), 32'(m_cnt == 9));
         cmp("move_ack", 32'(move_ack), 32'(m_ack));
         cmp("move_err", 32'(move_err), 32'(m_err != 0));
      end
   end

   task automatic drive(input logic [8:0] pl, input logic [8:0] pc,
                        input logic ill);
      PL_en = pl;
      PC_en = pc;
      illegal_move = ill;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      model_step();
   endtask

   task automatic reset_dut();
      reset = 0;
      #1;
      model_reset();
      drive(9'h0, 9'h0, 1'b0);
`ifdef UNDO_EN
      undo = 0;
`endif
      @(posedge clock);
      #1;
      reset = 1;
   endtask

   initial begin
      int errs;
      int kind;
      bit occ;
      logic [8:0] pl_r, pc_r;
      reset = 0;
      drive(9'h0, 9'h0, 1'b0);
`ifdef UNDO_EN
      undo = 0;
`endif
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1;
      chk_on = 1;
      cmp("rst_cnt", 32'(move_cnt), 32'd0);
      cmp("rst_turn", 32'(turn), 32'd0);

      // player takes cell 1
      drive(9'h001, 9'h0, 1'b0);
      tick();
      cmp("t1_pos1", 32'(pos1), 32'd1);
      cmp("t1_turn", 32'(turn), 32'd1);
      cmp("t1_cnt", 32'(move_cnt), 32'd1);
      cmp("t1_ack", 32'(move_ack), 32'd1);
      drive(9'h0, 9'h0, 1'b0);
      tick();
      cmp("t1_ack_pulse", 32'(move_ack), 32'd0);

      // detector-flagged computer move: error for exactly ERR_HOLD cycles
      drive(9'h0, 9'h001, 1'b1);
      tick();
      drive(9'h0, 9'h0, 1'b0);
      errs = 0;
      for (int i = 0; i < 8; i++) begin
         if (move_err) errs++;
         tick();
      end
      cmp("t2_err_len", 32'(errs), 32'd4);
      cmp("t2_pos1", 32'(pos1), 32'd1);

      // out-of-turn player request held for five cycles
      drive(9'h010, 9'h0, 1'b0);
      repeat (5) tick();
      cmp("t3_cnt", 32'(move_cnt), 32'd1);
      cmp("t3_pos5", 32'(pos5), 32'd0);
      drive(9'h0, 9'h0, 1'b0);
      tick();
      drive(9'h0, 9'h100, 1'b0);
      tick();
      cmp("t3_pos9", 32'(pos9), 32'd2);
      drive(9'h0, 9'h0, 1'b0);
      tick();

      // both sides at once
      drive(9'h002, 9'h004, 1'b0);
      tick();
      cmp("t4_pos2", 32'(pos2), 32'd0);
      cmp("t4_pos3", 32'(pos3), 32'd0);
      cmp("t4_err", 32'(move_err), 32'd1);
      cmp("t4_cnt", 32'(move_cnt), 32'd2);
      drive(9'h0, 9'h0, 1'b0);
      tick();

      // fill the board
      reset_dut();
      for (int i = 0; i < 9; i++) begin
         if (i % 2 == 0) drive(9'(1 << i), 9'h0, 1'b0);
         else drive(9'h0, 9'(1 << i), 1'b0);
         tick();
         drive(9'h0, 9'h0, 1'b0);
         tick();
      end
      cmp("t5_cnt", 32'(move_cnt), 32'd9);
      cmp("t5_full", 32'(board_full), 32'd1);
      cmp("t5_pos9", 32'(pos9), 32'd1);
      cmp("t5_pos8", 32'(pos8), 32'd2);
      drive(9'h001, 9'h0, 1'b0);
      tick();
      cmp("t5_err", 32'(move_err), 32'd1);
      cmp("t5_cnt_hold", 32'(move_cnt), 32'd9);
      drive(9'h0, 9'h0, 1'b0);
      tick();

      // reset during HOLD with error active
      reset_dut();
      drive(9'h0, 9'h002, 1'b0);
      tick();
      tick();
      cmp("t6_err_pre", 32'(move_err), 32'd1);
      reset = 0;
      #1;
      model_reset();
      cmp("t6_err", 32'(move_err), 32'd0);
      cmp("t6_cnt", 32'(move_cnt), 32'd0);
      cmp("t6_turn", 32'(turn), 32'd0);
      cmp("t6_full", 32'(board_full), 32'd0);
      cmp("t6_ack", 32'(move_ack), 32'd0);
      drive(9'h0, 9'h0, 1'b0);
      @(posedge clock);
      #1;
      reset = 1;

`ifdef UNDO_EN
      drive(9'h001, 9'h0, 1'b0);
      tick();
      drive(9'h0, 9'h0, 1'b0);
      tick();
      undo = 1;
      tick();
      undo = 0;
      cmp("u_pos1", 32'(pos1), 32'd0);
      cmp("u_cnt", 32'(move_cnt), 32'd0);
      cmp("u_turn", 32'(turn), 32'd0);
      tick();
`endif

      pl_r = 9'h0;
      pc_r = 9'h0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 2 ||
             (m_cnt == 9 && $urandom_range(0, 9) < 3)) begin
            reset_dut();
            pl_r = 9'h0;
            pc_r = 9'h0;
            continue;
         end
         kind = $urandom_range(0, 9);
         if (kind < 3) begin
            pl_r = 9'h0;
            pc_r = 9'h0;
         end else if (kind < 7) begin
            logic [8:0] b;
            b = 9'(1 << $urandom_range(0, 8));
            if (($urandom_range(0, 3) != 0) == m_turn) begin
               pl_r = 9'h0;
               pc_r = b;
            end else begin
               pl_r = b;
               pc_r = 9'h0;
            end
         end else if (kind == 7) begin
            pl_r = 9'($urandom);
            pc_r = 9'h0;
         end else if (kind == 8) begin
            pl_r = 9'(1 << $urandom_range(0, 8));
            pc_r = 9'(1 << $urandom_range(0, 8));
         end
         occ = 0;
         for (int k = 0; k < 9; k++)
            if ((pl_r[k] || pc_r[k]) && board[k] != 0) occ = 1;
         drive(pl_r, pc_r, occ || ($urandom_range(0, 9) == 0));
`ifdef UNDO_EN
         undo = ($urandom_range(0, 7) == 0);
`endif
         tick();
      end

      chk_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
